// File: rtl/bool_sweep_ctrl_if.sv
// Bundle of host-side and function-unit-side signals of the Boolean sweep
// sequencer. The slave modport is the sequencer's view; the master modport
// is the view of whatever supplies start/expected and the unit output F.
interface bool_sweep_ctrl_if;
   logic       start;
   logic [7:0] expected;
   logic       f_in;
   logic       A;
   logic       B;
   logic       C;
   logic       busy;
   logic       done;
   logic       pass;
   logic [7:0] mask;
   logic [3:0] err_count;
   logic [2:0] first_fail;

   modport slave (
      input  start, expected, f_in,
      output A, B, C, busy, done, pass, mask, err_count, first_fail
   );

   modport master (
      output start, expected, f_in,
      input  A, B, C, busy, done, pass, mask, err_count, first_fail
   );
endinterface

// File: rtl/bool_sweep_ctrl.sv
// Exhaustive sweep sequencer for a 3-input Boolean function unit.
// Steps {A,B,C} through minterms 0..7, holding each for SETTLE_CYCLES cycles,
// samples F into a measured truth-table mask and grades it against a mask
// latched when the sweep was accepted.
module bool_sweep_ctrl #(
   parameter int unsigned SETTLE_CYCLES = 1
) (
   input logic             clk,
   input logic             rst,
   bool_sweep_ctrl_if.slave bus
);

   localparam logic [3:0] SETTLE_LIM = 4'(SETTLE_CYCLES);

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      FINISH
   } state_t;

   state_t     state, state_nxt;
   logic [3:0] cnt, cnt_nxt;
   logic [2:0] idx, idx_nxt;
   logic [7:0] exp_lat, exp_lat_nxt;
   logic [7:0] mask_q, mask_nxt;
   logic       busy_q, busy_nxt;
   logic       done_q, done_nxt;
   logic       pass_q, pass_nxt;
   logic [3:0] err_q, err_nxt;
   logic [2:0] ff_q, ff_nxt;

   logic [7:0] diff;
   logic [3:0] diff_ones;
   logic [2:0] diff_low;
   logic [3:0] cnt_inc;

   // Grading of the measured mask: mismatch count and lowest mismatching minterm
   always_comb begin
      diff      = mask_q ^ exp_lat;
      diff_ones = '0;
      diff_low  = '0;
      for (int unsigned i = 0; i < 8; i++) begin
         diff_ones = diff_ones + {3'b000, diff[i]};
      end
      // Scan downward so the last hit is the lowest set bit
      for (int unsigned i = 8; i > 0; i--) begin
         if (diff[i-1]) begin
            diff_low = 3'(i - 1);
         end
      end
   end

   // Next-state and next-register values of the sweep sequencer
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      idx_nxt     = idx;
      exp_lat_nxt = exp_lat;
      mask_nxt    = mask_q;
      busy_nxt    = busy_q;
      done_nxt    = 1'b0;
      pass_nxt    = pass_q;
      err_nxt     = err_q;
      ff_nxt      = ff_q;
      cnt_inc     = cnt + 4'd1;

      case (state)
         IDLE: begin
            if (bus.start) begin
               exp_lat_nxt = bus.expected;
               idx_nxt     = '0;
               cnt_nxt     = '0;
               mask_nxt    = '0;
               pass_nxt    = 1'b0;
               err_nxt     = '0;
               ff_nxt      = '0;
               busy_nxt    = 1'b1;
               state_nxt   = SETTLE;
            end
         end

         SETTLE: begin
            if (cnt_inc == SETTLE_LIM) begin
               mask_nxt[idx] = bus.f_in;
               cnt_nxt       = '0;
               if (idx != 3'd7) begin
                  idx_nxt = idx + 3'd1;
               end else begin
                  state_nxt = FINISH;
               end
            end else begin
               cnt_nxt = cnt_inc;
            end
         end

         FINISH: begin
            err_nxt   = diff_ones;
            pass_nxt  = (diff_ones == 4'd0);
            ff_nxt    = diff_low;
            done_nxt  = 1'b1;
            busy_nxt  = 1'b0;
            idx_nxt   = '0;
            state_nxt = IDLE;
         end

         default: begin
            state_nxt = IDLE;
            idx_nxt   = '0;
            cnt_nxt   = '0;
            busy_nxt  = 1'b0;
         end
      endcase
   end

   // State and result registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         idx     <= '0;
         exp_lat <= '0;
         mask_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         err_q   <= '0;
         ff_q    <= '0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         idx     <= idx_nxt;
         exp_lat <= exp_lat_nxt;
         mask_q  <= mask_nxt;
         busy_q  <= busy_nxt;
         done_q  <= done_nxt;
         pass_q  <= pass_nxt;
         err_q   <= err_nxt;
         ff_q    <= ff_nxt;
      end
   end

   // ABC is the registered minterm index; idx stays 0 whenever idle
   assign bus.A          = idx[2];
   assign bus.B          = idx[1];
   assign bus.C          = idx[0];
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.pass       = pass_q;
   assign bus.mask       = mask_q;
   assign bus.err_count  = err_q;
   assign bus.first_fail = ff_q;

endmodule

// File: tb/tb_bool_sweep_ctrl.sv
// Self-checking bench for bool_sweep_ctrl: two instances (settle 1 and 3)
// drive configurable function units; a timing-level model predicts every
// output each cycle, and directed sweeps pin results to hand-computed values.
module tb_bool_sweep_ctrl;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   bool_sweep_ctrl_if if0 ();
   bool_sweep_ctrl_if if1 ();

   bool_sweep_ctrl #(.SETTLE_CYCLES(1)) dut0 (.clk(clk), .rst(rst), .bus(if0));
   bool_sweep_ctrl #(.SETTLE_CYCLES(3)) dut1 (.clk(clk), .rst(rst), .bus(if1));

   // Function units: truth-table lookup, optionally behind two register stages
   logic [7:0] lut [2];
   int         dly [2];
   logic [1:0] pipe0 = 2'b00;
   logic [1:0] pipe1 = 2'b00;

   always @(posedge clk) begin
      pipe0 <= {pipe0[0], lut[0][{if0.A, if0.B, if0.C}]};
      pipe1 <= {pipe1[0], lut[1][{if1.A, if1.B, if1.C}]};
   end

   assign if0.f_in = (dly[0] == 2) ? pipe0[1] : lut[0][{if0.A, if0.B, if0.C}];
   assign if1.f_in = (dly[1] == 2) ? pipe1[1] : lut[1][{if1.A, if1.B, if1.C}];

   // Per-instance views
   logic [1:0] st_v, busy_v, done_v, pass_v;
   logic [7:0] ex_v [2];
   logic [7:0] mask_v [2];
   logic [2:0] abc_v [2];
   logic [3:0] err_v [2];
   logic [2:0] ff_v [2];

   assign st_v   = {if1.start, if0.start};
   assign busy_v = {if1.busy, if0.busy};
   assign done_v = {if1.done, if0.done};
   assign pass_v = {if1.pass, if0.pass};
   assign ex_v[0] = if0.expected;
   assign ex_v[1] = if1.expected;
   assign mask_v[0] = if0.mask;
   assign mask_v[1] = if1.mask;
   assign abc_v[0] = {if0.A, if0.B, if0.C};
   assign abc_v[1] = {if1.A, if1.B, if1.C};
   assign err_v[0] = if0.err_count;
   assign err_v[1] = if1.err_count;
   assign ff_v[0] = if0.first_fail;
   assign ff_v[1] = if1.first_fail;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // F seen during cycle c (counted from acceptance) is the table value of the
   // minterm applied D cycles earlier; minterm at cycle c is c/S, 0 before start.
   function automatic logic [7:0] predict(input logic [7:0] l, input int s, input int d);
      logic [7:0] m;
      int c;
      for (int i = 0; i < 8; i++) begin
         c = (i + 1) * s - 1 - d;
         m[i] = (c < 0) ? l[0] : l[c / s];
      end
      return m;
   endfunction

   function automatic int lowest(input logic [7:0] v);
      int r = 0;
      for (int i = 7; i >= 0; i--) if (v[i]) r = i;
      return r;
   endfunction

   // Model: sweep k accepted at edge e0 occupies edges e0..e0+8S, done after e0+8S+1
   int         sc [2] = '{1, 3};
   int         cyc = 0;
   bit         act [2];
   int         e0 [2];
   logic [7:0] pm [2];
   logic [7:0] exl [2];
   int         pe [2];
   int         pf [2];
   bit         pp [2];
   bit         chk_en = 1'b0;

   always @(posedge clk) begin
      cyc = cyc + 1;
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            act[k] = 1'b0;
         end else if (st_v[k] && !(act[k] && (cyc - 1 <= e0[k] + 8 * sc[k]))) begin
            act[k] = 1'b1;
            e0[k]  = cyc;
            exl[k] = ex_v[k];
            pm[k]  = predict(lut[k], sc[k], dly[k]);
            pe[k]  = $countones(pm[k] ^ exl[k]);
            pf[k]  = lowest(pm[k] ^ exl[k]);
            pp[k]  = (pm[k] == exl[k]);
         end
      end
   end

   // Compare process: every cycle, every output of both instances
   always @(negedge clk) begin
      if (chk_en) begin
         for (int k = 0; k < 2; k++) begin
            bit         b, d, res;
            int         step;
            logic [2:0] abc_e;
            b = act[k] && (cyc <= e0[k] + 8 * sc[k]);
            d = act[k] && (cyc == e0[k] + 8 * sc[k] + 1);
            abc_e = 3'd0;
            if (b) begin
               step  = (cyc - e0[k]) / sc[k];
               abc_e = (step > 7) ? 3'd7 : 3'(step);
            end
            res = act[k] && !b;
            check($sformatf("busy%0d", k), 32'(busy_v[k]), 32'(b));
            check($sformatf("done%0d", k), 32'(done_v[k]), 32'(d));
            check($sformatf("abc%0d", k), 32'(abc_v[k]), 32'(abc_e));
            check($sformatf("pass%0d", k), 32'(pass_v[k]), res ? 32'(pp[k]) : 32'd0);
            check($sformatf("err%0d", k), 32'(err_v[k]), res ? 32'(pe[k]) : 32'd0);
            check($sformatf("ff%0d", k), 32'(ff_v[k]), res ? 32'(pf[k]) : 32'd0);
            if (!b) check($sformatf("mask%0d", k), 32'(mask_v[k]), res ? 32'(pm[k]) : 32'd0);
         end
      end
   end

   task automatic set_start(input int k, input logic v);
      if (k == 0) if0.start = v; else if1.start = v;
   endtask

   task automatic set_exp(input int k, input logic [7:0] v);
      if (k == 0) if0.expected = v; else if1.expected = v;
   endtask

   // One-cycle start pulse; lat = edges from acceptance to done
   task automatic sweep(input int k, input logic [7:0] ex, output int lat);
      @(posedge clk); #1;
      set_exp(k, ex);
      set_start(k, 1'b1);
      @(posedge clk); #1;
      set_start(k, 1'b0);
      lat = 0;
      while (!done_v[k] && lat < 300) begin
         @(posedge clk); #1;
         lat++;
      end
      if (lat >= 300) check("done_timeout", 32'(lat), 32'd0);
   endtask

   task automatic results(input string nm, input int k, input int lat, input int lat_e,
                          input logic [7:0] m, input logic p, input logic [3:0] e,
                          input logic [2:0] f);
      check({nm, "_lat"},  32'(lat), 32'(lat_e));
      check({nm, "_mask"}, 32'(mask_v[k]), 32'(m));
      check({nm, "_pass"}, 32'(pass_v[k]), 32'(p));
      check({nm, "_err"},  32'(err_v[k]), 32'(e));
      check({nm, "_ff"},   32'(ff_v[k]), 32'(f));
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int lat;
      int dn [$];
      int ndone;
      lut[0] = 8'h65; lut[1] = 8'h65;
      dly[0] = 0;     dly[1] = 2;
      if0.start = 1'b0; if1.start = 1'b0;
      if0.expected = 8'h00; if1.expected = 8'h00;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 chk_en = 1'b1;
      check("rst_busy", 32'(busy_v), 32'd0);
      check("rst_mask", 32'(mask_v[0]), 32'd0);
      check("rst_abc",  32'(abc_v[1]), 32'd0);
      rst = 1'b0;
      repeat (2) @(posedge clk);

      // Correct unit, settle 1
      sweep(0, 8'h65, lat);
      results("ok65", 0, lat, 9, 8'h65, 1'b1, 4'd0, 3'd0);
      // Missing m5 term
      lut[0] = 8'h45;
      sweep(0, 8'h65, lat);
      results("miss5", 0, lat, 9, 8'h45, 1'b0, 4'd1, 3'd5);
      // Stuck at 0 / stuck at 1
      lut[0] = 8'h00;
      sweep(0, 8'h65, lat);
      results("stuck0", 0, lat, 9, 8'h00, 1'b0, 4'd4, 3'd0);
      lut[0] = 8'hFF;
      sweep(0, 8'h65, lat);
      results("stuck1", 0, lat, 9, 8'hFF, 1'b0, 4'd4, 3'd1);
      // Two-stage unit with settle 3 passes
      sweep(1, 8'h65, lat);
      results("pipe_s3", 1, lat, 25, 8'h65, 1'b1, 4'd0, 3'd0);
      // Same unit with settle 1 sees stale outputs
      lut[0] = 8'h65; dly[0] = 2;
      repeat (4) @(posedge clk);
      sweep(0, 8'h65, lat);
      results("pipe_s1", 0, lat, 9, 8'h97, 1'b0, 4'd5, 3'd1);
      dly[0] = 0;
      repeat (4) @(posedge clk);

      // start held high: back-to-back sweeps, expected change mid-sweep ignored
      @(posedge clk); #1;
      if0.expected = 8'h65;
      if0.start = 1'b1;
      @(posedge clk); #1;
      for (int t = 1; t <= 29; t++) begin
         @(posedge clk); #1;
         if (t == 3)  if0.expected = 8'h00;
         if (t == 13) if0.expected = 8'h65;
         if (if0.done) dn.push_back(t);
         if (t == 9)  check("cont_pass1", 32'(if0.pass), 32'd1);
         if (t == 19) check("cont_err2", 32'(if0.err_count), 32'd4);
         if (t == 29) check("cont_pass3", 32'(if0.pass), 32'd1);
      end
      if0.start = 1'b0;
      check("cont_ndone", 32'(dn.size()), 32'd3);
      if (dn.size() == 3) begin
         check("cont_d0", 32'(dn[0]), 32'd9);
         check("cont_d1", 32'(dn[1]), 32'd19);
         check("cont_d2", 32'(dn[2]), 32'd29);
      end
      repeat (3) @(posedge clk);

      // Reset at E0+4 aborts without done
      @(posedge clk); #1;
      if0.start = 1'b1;
      @(posedge clk); #1;
      if0.start = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("abort_busy", 32'(if0.busy), 32'd0);
      check("abort_abc",  32'(abc_v[0]), 32'd0);
      check("abort_mask", 32'(if0.mask), 32'd0);
      check("abort_pass", 32'(if0.pass), 32'd0);
      ndone = 0;
      repeat (15) begin
         @(posedge clk); #1;
         if (if0.done) ndone++;
      end
      check("abort_nodone", 32'(ndone), 32'd0);
      sweep(0, 8'h65, lat);
      results("after_rst", 0, lat, 9, 8'h65, 1'b1, 4'd0, 3'd0);

      repeat (3) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/bool_sweep_ctrl.md
Name: bool_sweep_ctrl

Overview:
- Sequencer that exhaustively exercises a 3-input Boolean function unit (A, B, C -> F) by stepping ABC through minterms 0..7.
- Samples F for each minterm and assembles the measured truth table as an 8-bit minterm mask.
- Compares the mask against an expected minterm mask and reports pass/fail, mismatch count and lowest failing minterm.
- Sits between a test/config host and any function unit (dataflow, behavioural or structural style); the unit's inputs are driven only by this block.

Parameters:
- SETTLE_CYCLES, 1, cycles from an ABC change to the F sample edge; legal range 1..15. A unit with D internal register stages requires SETTLE_CYCLES >= D+1.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous reset, active-high
- start  input  1  request a sweep; accepted only when busy=0
- expected  input  8  expected mask; bit i = required F for {A,B,C}=i; latched at start acceptance
- f_in  input  1  F output of the function unit
- A  output  1  function input, MSB of minterm index (registered)
- B  output  1  function input, middle bit (registered)
- C  output  1  function input, LSB (registered)
- busy  output  1  high while a sweep is in progress
- done  output  1  one-cycle pulse when a sweep completes
- pass  output  1  1 if mask == latched expected; held until next acceptance
- mask  output  8  measured truth table; bit i = F sampled at minterm i
- err_count  output  4  number of mismatching bits, 0..8
- first_fail  output  3  lowest mismatching minterm index; 0 when pass=1

Behaviour:
- Reset (rst=1 at an edge), taking effect on that edge: state IDLE; A=B=C=0; busy=0, done=0, pass=0, mask=0, err_count=0, first_fail=0; idx and settle counter cleared; latched expected cleared.
- Reset mid-sweep aborts the sweep with no done pulse; rst has priority over start.
- States: IDLE, SETTLE, FINISH.
- IDLE:
  - A=B=C=0.
  - start=1 at edge E0: latch expected; idx=0 (ABC=000 driven from E0); clear mask, pass, err_count and first_fail; settle counter=0; busy=1; go to SETTLE.
- SETTLE:
  - Counter increments each edge.
  - On the edge where counter reaches SETTLE_CYCLES, counted from the ABC change, sample f_in into mask[idx].
  - On that same edge: if idx<7, increment idx (ABC updates on that edge), reset counter and stay in SETTLE; if idx=7, go to FINISH.
  - Sample edges for minterm i fall at E0+(i+1)*SETTLE_CYCLES.
  - ABC is stable for exactly SETTLE_CYCLES cycles per minterm.
- FINISH (single cycle), on its exit edge:
  - err_count = popcount(mask XOR expected_latched);
  - pass = (err_count==0);
  - first_fail = lowest set bit index of the XOR, else 0;
  - done=1 for one cycle; busy=0; ABC=000; go to IDLE.
  - done rises at edge E0+8*SETTLE_CYCLES+1; busy is high from E0 through that edge.
- start while busy=1 is ignored and not queued.
- start during the done cycle (state IDLE) is accepted, giving back-to-back sweeps. The outputs of the finishing sweep are valid during the done cycle, and then clear on acceptance.
- Changes to expected during a sweep have no effect.
- mask updates bit by bit during a sweep. It is only meaningful with done=1 or afterwards in IDLE.
- Results hold indefinitely in IDLE.
- Counter width 4 bits; idx 3 bits with no wrap beyond 7; err_count 4 bits covers value 8.

Test Plan:
- SETTLE=1, expected=8'h65 (Σ0,2,5,6), correct combinational unit, start pulse at E0 -> ABC steps 000..111 one per cycle; done at E0+9; mask=8'h65, pass=1, err_count=0, first_fail=0.
- Same setup, unit with m5 term missing -> mask=8'h45, pass=0, err_count=1, first_fail=5.
- Unit output stuck at 0, expected=8'h65 -> mask=8'h00, err_count=4, first_fail=0, pass=0. Stuck at 1 -> mask=8'hFF, err_count=4, first_fail=1.
- SETTLE=3, unit with 2 register stages, expected=8'h65 -> each ABC held 3 cycles; done at E0+25; pass=1. The same unit with SETTLE=1 -> pass=0.
- start held high continuously, SETTLE=1 -> sweeps restart in each done cycle (period 10 cycles); a start asserted mid-sweep causes no restart; expected changed mid-sweep is ignored.
- rst asserted at E0+4 -> next cycle all outputs at reset values, no done pulse; subsequent start performs a full, correct sweep.
